// File: rtl/mem_pkg.sv
// Shared constants and types for the data-memory port arbiter.
package mem_pkg;
  localparam int DEPTH = 10;
  localparam int AW    = 8;
  localparam int DW    = 16;

  localparam logic [1:0] UNLOCKED = 2'd0;
  localparam logic [1:0] LOCKED0  = 2'd1;
  localparam logic [1:0] LOCKED1  = 2'd2;

  // rd distinguishes a read response (carries lw_value) from a write acknowledge
  typedef struct packed {
    logic valid;
    logic port;
    logic err;
    logic rd;
  } resp_t;

  function automatic logic in_range(input logic [AW-1:0] a);
    return a < AW'(DEPTH);
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester ports plus memory command/read-data bus of the arbiter.
interface mem_port_arbiter_if;
  import mem_pkg::*;

  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_read, mem_write;
  logic [AW-1:0] addr;
  logic [DW-1:0] sw_value, lw_value;

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, lw_value,
    output gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1, rdata0, rdata1,
           mem_read, mem_write, addr, sw_value
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, lw_value,
    input  gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1, rdata0, rdata1,
           mem_read, mem_write, addr, sw_value
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; a valid lock forces the grant to the lock owner.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_lock_vld,
  input  logic       i_lock_port,
  output logic [1:0] o_gnt,
  output logic       o_winner
);
  logic r_rr_last;

  always_comb begin
    o_gnt    = 2'b00;
    o_winner = 1'b0;
    if (i_lock_vld) begin
      // owner keeps the port; if it is not requesting, nobody is granted
      o_winner            = i_lock_port;
      o_gnt[i_lock_port]  = i_req[i_lock_port];
    end else begin
      case (i_req)
        2'b10:   o_winner = 1'b1;
        2'b11:   o_winner = ~r_rr_last;
        default: o_winner = 1'b0;
      endcase
      o_gnt[o_winner] = |i_req;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       r_rr_last <= 1'b1;
    else if (|o_gnt) r_rr_last <= o_winner;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates CPU (port 0) and loader (port 1) onto the data memory and returns
// responses two cycles after the grant.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int MAX_LOCK = 8
) (
  input logic              clock,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_LOCK + 1);

  logic [1:0]    r_lock_state;
  logic [CW-1:0] r_lock_cnt;
  logic          r_mem_read, r_mem_write;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_sw_value;
  resp_t [2:1]   r_vld_pipe;

  logic          w_locked, w_own, w_own_req, w_own_lock, w_timeout, w_lock_vld;
  logic [1:0]    w_gnt;
  logic          w_winner, w_grant, w_win_we, w_win_lock, w_win_ok, w_cmd;
  logic [AW-1:0] w_win_addr;
  logic [DW-1:0] w_win_wdata;
  resp_t         w_rsp;
  logic          w_rv0, w_rv1;

  assign w_locked   = r_lock_state != UNLOCKED;
  assign w_own      = r_lock_state == LOCKED1;
  assign w_own_req  = w_own ? bus.req1  : bus.req0;
  assign w_own_lock = w_own ? bus.lock1 : bus.lock0;
  assign w_timeout  = w_locked && (r_lock_cnt == CW'(MAX_LOCK));
  // an idle owner that also dropped lock releases in the same cycle
  assign w_lock_vld = w_locked && !w_timeout && (w_own_req || w_own_lock);

  rr_arbiter2 u_arb (
    .clock      (clock),
    .reset      (reset),
    .i_req      ({bus.req1, bus.req0}),
    .i_lock_vld (w_lock_vld),
    .i_lock_port(w_own),
    .o_gnt      (w_gnt),
    .o_winner   (w_winner)
  );

  assign bus.gnt0    = w_gnt[0];
  assign bus.gnt1    = w_gnt[1];
  assign w_grant     = |w_gnt;
  assign w_win_we    = w_winner ? bus.we1    : bus.we0;
  assign w_win_lock  = w_winner ? bus.lock1  : bus.lock0;
  assign w_win_addr  = w_winner ? bus.addr1  : bus.addr0;
  assign w_win_wdata = w_winner ? bus.wdata1 : bus.wdata0;
  assign w_win_ok    = in_range(w_win_addr);
  assign w_cmd       = w_grant && w_win_ok;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lock_state <= UNLOCKED;
      r_lock_cnt   <= '0;
    end else if (w_lock_vld) begin
      if (w_grant && !w_win_lock) begin
        r_lock_state <= UNLOCKED;
        r_lock_cnt   <= '0;
      end else begin
        r_lock_cnt <= r_lock_cnt + CW'(1);
      end
    end else if (w_grant && w_win_lock) begin
      r_lock_state <= w_winner ? LOCKED1 : LOCKED0;
      r_lock_cnt   <= CW'(1);
    end else begin
      r_lock_state <= UNLOCKED;
      r_lock_cnt   <= '0;
    end
  end

  // out-of-range accesses still flow down the response pipe, flagged as errors
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_addr        <= '0;
      r_sw_value    <= '0;
      r_vld_pipe    <= '0;
    end else begin
      r_mem_read    <= w_cmd && !w_win_we;
      r_mem_write   <= w_cmd && w_win_we;
      r_addr        <= w_cmd ? w_win_addr  : '0;
      r_sw_value    <= w_cmd ? w_win_wdata : '0;
      r_vld_pipe[1] <= '{valid: w_grant, port: w_winner, err: !w_win_ok, rd: !w_win_we};
      r_vld_pipe[2] <= r_vld_pipe[1];
    end
  end

  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign bus.addr      = r_addr;
  assign bus.sw_value  = r_sw_value;

  assign w_rsp       = r_vld_pipe[2];
  assign w_rv0       = w_rsp.valid && !w_rsp.port;
  assign w_rv1       = w_rsp.valid && w_rsp.port;
  assign bus.rvalid0 = w_rv0;
  assign bus.rvalid1 = w_rv1;
  assign bus.rerr0   = w_rv0 && w_rsp.err;
  assign bus.rerr1   = w_rv1 && w_rsp.err;
  assign bus.rdata0  = (w_rv0 && w_rsp.rd && !w_rsp.err) ? bus.lw_value : '0;
  assign bus.rdata1  = (w_rv1 && w_rsp.rd && !w_rsp.err) ? bus.lw_value : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 10-word memory model on the memory bus.
module tb_mem_port_arbiter;
  logic clock;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MAX_LOCK(8)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // memory model: synchronous write, registered read, preloaded on the first edge
  logic [15:0] mem [10];
  logic [15:0] exp_mem [10];
  logic        mem_init_done = 1'b0;
  always @(posedge clock) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 10; i++) mem[i] <= 16'h1000 + 16'(i);
      mem[3] <= 16'h00A5;
      mem[5] <= 16'h0050;
      mem_init_done <= 1'b1;
    end else begin
      if (bus.mem_write && bus.addr < 8'd10) mem[bus.addr[3:0]] <= bus.sw_value;
      if (bus.mem_read) bus.lw_value <= (bus.addr < 8'd10) ? mem[bus.addr[3:0]] : 16'hDEAD;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] outs();
    return {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.rerr0, bus.rerr1,
            bus.rdata0, bus.rdata1, bus.mem_read, bus.mem_write, bus.addr, bus.sw_value};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_checks++;
    if (outs() !== 64'h0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs()); end
    reset = 1'b0;
    step();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'd3;
    #1;
    n_checks++;
    if (bus.gnt0 !== 1'b1) begin n_fail++; $display("FAIL reset_pre_gnt0: got %b expected 1", bus.gnt0); end
    step();
    bus.req0 = 1'b0;
    n_checks++;
    if (bus.mem_read !== 1'b1) begin n_fail++; $display("FAIL reset_pre_mem_read: got %b expected 1", bus.mem_read); end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (outs() !== 64'h0) begin n_fail++; $display("FAIL reset_midread_outputs: got %h expected 0", outs()); end
    #2 reset = 1'b0;
    step();
    n_checks++;
    if ({bus.rvalid0, bus.rvalid1} !== 2'b00) begin n_fail++; $display("FAIL reset_dropped_resp: got %b expected 00", {bus.rvalid0, bus.rvalid1}); end
    step();
    n_checks++;
    if ({bus.rvalid0, bus.rvalid1} !== 2'b00) begin n_fail++; $display("FAIL reset_dropped_resp2: got %b expected 00", {bus.rvalid0, bus.rvalid1}); end
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    #1;
    n_checks++;
    if ({bus.gnt1, bus.gnt0} !== 2'b01) begin n_fail++; $display("FAIL reset_first_priority: got %b expected 01", {bus.gnt1, bus.gnt0}); end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    #1;
  endtask

  task automatic test_single_read();
    step();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'd3;
    #1;
    n_checks++;
    if ({bus.gnt1, bus.gnt0} !== 2'b01) begin n_fail++; $display("FAIL read_gnt: got %b expected 01", {bus.gnt1, bus.gnt0}); end
    step();
    bus.req0 = 1'b0;
    n_checks++;
    if ({bus.mem_read, bus.mem_write, bus.addr} !== {1'b1, 1'b0, 8'd3})
      begin n_fail++; $display("FAIL read_cmd: got %h expected %h", {bus.mem_read, bus.mem_write, bus.addr}, {1'b1, 1'b0, 8'd3}); end
    step();
    n_checks++;
    if ({bus.rvalid0, bus.rerr0, bus.rdata0, bus.rvalid1} !== {1'b1, 1'b0, 16'h00A5, 1'b0})
      begin n_fail++; $display("FAIL read_resp: got %h expected %h", {bus.rvalid0, bus.rerr0, bus.rdata0, bus.rvalid1}, {1'b1, 1'b0, 16'h00A5, 1'b0}); end
    step();
    n_checks++;
    if (bus.rvalid0 !== 1'b0) begin n_fail++; $display("FAIL read_pulse: got %b expected 0", bus.rvalid0); end
  endtask

  task automatic test_write();
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'd7; bus.wdata1 = 16'h1234;
    #1;
    n_checks++;
    if ({bus.gnt1, bus.gnt0} !== 2'b10) begin n_fail++; $display("FAIL write_gnt: got %b expected 10", {bus.gnt1, bus.gnt0}); end
    step();
    bus.req1 = 1'b0; bus.we1 = 1'b0;
    n_checks++;
    if ({bus.mem_write, bus.mem_read, bus.addr, bus.sw_value} !== {1'b1, 1'b0, 8'd7, 16'h1234})
      begin n_fail++; $display("FAIL write_cmd: got %h expected %h", {bus.mem_write, bus.mem_read, bus.addr, bus.sw_value}, {1'b1, 1'b0, 8'd7, 16'h1234}); end
    exp_mem[7] = 16'h1234;
    step();
    n_checks++;
    if ({bus.rvalid1, bus.rerr1, bus.rdata1} !== {1'b1, 1'b0, 16'h0000})
      begin n_fail++; $display("FAIL write_ack: got %h expected %h", {bus.rvalid1, bus.rerr1, bus.rdata1}, {1'b1, 1'b0, 16'h0000}); end
    n_checks++;
    if (mem[7] !== exp_mem[7]) begin n_fail++; $display("FAIL write_mem: got %h expected %h", mem[7], exp_mem[7]); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_g;
    logic [33:0] exp_r;
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = 8'd1; bus.addr1 = 8'd2;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      #1;
      if (k < 4) begin
        exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
        n_checks++;
        if ({bus.gnt1, bus.gnt0} !== exp_g) begin n_fail++; $display("FAIL b2b_gnt[%0d]: got %b expected %b", k, {bus.gnt1, bus.gnt0}, exp_g); end
      end
      if (k < 2)           exp_r = 34'h0;
      else if (k % 2 == 0) exp_r = {1'b0, 1'b1, 16'h0000, exp_mem[1]};
      else                 exp_r = {1'b1, 1'b0, exp_mem[2], 16'h0000};
      n_checks++;
      if ({bus.rvalid1, bus.rvalid0, bus.rdata1, bus.rdata0} !== exp_r)
        begin n_fail++; $display("FAIL b2b_resp[%0d]: got %h expected %h", k, {bus.rvalid1, bus.rvalid0, bus.rdata1, bus.rdata0}, exp_r); end
      step();
    end
  endtask

  task automatic test_out_of_range();
    int bad;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'd12; bus.wdata1 = 16'hBEEF;
    #1;
    n_checks++;
    if ({bus.gnt1, bus.gnt0} !== 2'b10) begin n_fail++; $display("FAIL oor_gnt: got %b expected 10", {bus.gnt1, bus.gnt0}); end
    step();
    bus.req1 = 1'b0; bus.we1 = 1'b0;
    n_checks++;
    if ({bus.mem_write, bus.mem_read} !== 2'b00) begin n_fail++; $display("FAIL oor_strobes: got %b expected 00", {bus.mem_write, bus.mem_read}); end
    step();
    n_checks++;
    if ({bus.rvalid0, bus.rvalid1, bus.rerr1, bus.rdata1} !== {1'b0, 1'b1, 1'b1, 16'h0000})
      begin n_fail++; $display("FAIL oor_resp: got %h expected %h", {bus.rvalid0, bus.rvalid1, bus.rerr1, bus.rdata1}, {1'b0, 1'b1, 1'b1, 16'h0000}); end
    bad = 0;
    for (int i = 0; i < 10; i++) if (mem[i] !== exp_mem[i]) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL oor_mem_intact: got %0d changed words expected 0", bad); end
    step();
  endtask

  task automatic test_lock_rmw();
    logic [15:0] rmw;
    bus.req0 = 1'b1; bus.lock0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'd5;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'd2;
    #1;
    n_checks++;
    if ({bus.gnt1, bus.gnt0} !== 2'b01) begin n_fail++; $display("FAIL rmw_rd_gnt: got %b expected 01", {bus.gnt1, bus.gnt0}); end
    step();
    bus.req0 = 1'b0;
    #1;
    n_checks++;
    if ({bus.gnt1, bus.gnt0} !== 2'b00) begin n_fail++; $display("FAIL rmw_locked_stall: got %b expected 00", {bus.gnt1, bus.gnt0}); end
    step();
    n_checks++;
    if ({bus.rvalid0, bus.rdata0} !== {1'b1, 16'h0050}) begin n_fail++; $display("FAIL rmw_rd_data: got %h expected %h", {bus.rvalid0, bus.rdata0}, {1'b1, 16'h0050}); end
    rmw = bus.rdata0 + 16'd1;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.wdata0 = rmw; bus.lock0 = 1'b0;
    #1;
    n_checks++;
    if ({bus.gnt1, bus.gnt0} !== 2'b01) begin n_fail++; $display("FAIL rmw_wr_gnt: got %b expected 01", {bus.gnt1, bus.gnt0}); end
    step();
    bus.req0 = 1'b0; bus.we0 = 1'b0;
    #1;
    n_checks++;
    if ({bus.mem_write, bus.addr, bus.sw_value} !== {1'b1, 8'd5, 16'h0051})
      begin n_fail++; $display("FAIL rmw_wr_cmd: got %h expected %h", {bus.mem_write, bus.addr, bus.sw_value}, {1'b1, 8'd5, 16'h0051}); end
    n_checks++;
    if ({bus.gnt1, bus.gnt0} !== 2'b10) begin n_fail++; $display("FAIL rmw_release_gnt1: got %b expected 10", {bus.gnt1, bus.gnt0}); end
    exp_mem[5] = 16'h0051;
    step();
    bus.req1 = 1'b0;
    n_checks++;
    if ({bus.rvalid0, bus.rerr0, bus.rdata0} !== {1'b1, 1'b0, 16'h0000})
      begin n_fail++; $display("FAIL rmw_wr_ack: got %h expected %h", {bus.rvalid0, bus.rerr0, bus.rdata0}, {1'b1, 1'b0, 16'h0000}); end
    step();
    n_checks++;
    if ({bus.rvalid1, bus.rdata1} !== {1'b1, exp_mem[2]}) begin n_fail++; $display("FAIL rmw_port1_resp: got %h expected %h", {bus.rvalid1, bus.rdata1}, {1'b1, exp_mem[2]}); end
    n_checks++;
    if (mem[5] !== exp_mem[5]) begin n_fail++; $display("FAIL rmw_mem5: got %h expected %h", mem[5], exp_mem[5]); end
    step();
  endtask

  task automatic test_lock_timeout();
    logic [1:0] exp_g;
    bus.req1 = 1'b1; bus.lock1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'd2;
    bus.we0 = 1'b0; bus.addr0 = 8'd1; bus.lock0 = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k == 1) bus.req0 = 1'b1;
      #1;
      exp_g = (k < 8) ? 2'b10 : 2'b01;
      n_checks++;
      if ({bus.gnt1, bus.gnt0} !== exp_g) begin n_fail++; $display("FAIL timeout_gnt[%0d]: got %b expected %b", k, {bus.gnt1, bus.gnt0}, exp_g); end
      step();
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.lock1 = 1'b0;
    step(); step(); step();
  endtask

  initial begin
    reset = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.lock0 = 1'b0; bus.lock1 = 1'b0; bus.addr0 = '0; bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    for (int i = 0; i < 10; i++) exp_mem[i] = 16'h1000 + 16'(i);
    exp_mem[3] = 16'h00A5;
    exp_mem[5] = 16'h0050;
    test_reset();
    test_single_read();
    test_write();
    test_back_to_back();
    test_out_of_range();
    test_lock_rmw();
    test_lock_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 10-word x 16-bit data memory (synchronous write, registered read, 8-bit address).
- Port 0 is the CPU load/store unit; port 1 is the debug/DMA loader.
- Grants one access per cycle using round-robin with optional lock for read-modify-write.
- Rejects addresses at or above DEPTH without touching memory; registers the memory command and returns read data to the winning port with fixed latency.

Parameters:
- DEPTH, 10, number of valid memory words; addresses >= DEPTH are out of range
- AW, 8, address width
- DW, 16, data width
- MAX_LOCK, 8, maximum consecutive cycles one port may hold a lock before forced release

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req0 / req1  in  1  access request, held until granted
- we0 / we1  in  1  1 = write, 0 = read; valid with req
- lock0 / lock1  in  1  keep ownership after this grant
- addr0 / addr1  in  AW  word address
- wdata0 / wdata1  in  DW  write data
- gnt0 / gnt1  out  1  combinational; request accepted at this clock edge
- rvalid0 / rvalid1  out  1  read response valid, one-cycle pulse
- rerr0 / rerr1  out  1  out-of-range error, coincident with response pulse
- rdata0 / rdata1  out  DW  read data; lw_value when rvalid, else 0
- mem_read  out  1  registered memory read strobe
- mem_write  out  1  registered memory write strobe
- addr  out  AW  registered memory address
- sw_value  out  DW  registered memory write data
- lw_value  in  DW  memory read data, valid the cycle after mem_read is sampled

Behaviour:
- Reset, asynchronous: all outputs 0; rr_last = 1 so port 0 has first priority; lock owner none; lock counter 0; pipeline valid bits cleared. Accesses in flight at reset are dropped and produce no response.
- Arbitration, combinational, cycle A:
  - If a lock owner exists and its req is high, the owner wins.
  - If the owner's req is low, no grant is issued this cycle (other port stalls) unless the lock is released.
  - Otherwise, with one requester, that port wins.
  - With both requesting, the port != rr_last wins.
  - gntN = winner == N. At most one gnt per cycle.
- On the accept edge ending cycle A:
  - rr_last <= winner.
  - If out of range (addr >= DEPTH): mem_read = mem_write = 0 in cycle A+1; error token enters pipeline.
  - If in range: mem_write = weN, mem_read = !weN, addr/sw_value = request fields, all held for cycle A+1 only. Strobes return to 0 when no grant.
- Response, cycle A+2, all cases are one-cycle pulses:
  - In-range read: rvalidN = 1, rdataN = lw_value.
  - In-range write: rvalidN = 1, rdataN = 0 (write acknowledge).
  - Out-of-range access: rvalidN = 1, rerrN = 1, rdataN = 0.
  - Implementation: 2-stage valid/port/err pipeline. Back-to-back grants yield back-to-back responses; ordering is preserved.
- Lock FSM states:
  - UNLOCKED -> LOCKED(N): on grant to N with lockN = 1; counter <= 1.
  - LOCKED(N): counter increments each cycle.
  - LOCKED(N) -> UNLOCKED: when lockN = 0 sampled at a grant to N, when req N and lockN are both low, or when counter reaches MAX_LOCK.
  - Forced release (MAX_LOCK): rr_last = N, so the other port wins the next contention.
  - lockN on a non-winning port is ignored.
- Simultaneous reads and writes to the same address from different ports are serialized by arbitration: the earlier grant completes in memory first.
- No combinational path from lw_value to any gnt.

Decomposition:
- Shared package mem_pkg: DEPTH, AW, DW constants; lock state enum {UNLOCKED, LOCKED0, LOCKED1}; response struct {valid, port, err}.
- One natural sub-module: rr_arbiter2 (2-way round-robin with rr_last and lock override).
- Command/response pipeline stays in the top level.

Test Plan:
- Reset: assert reset mid-read (after gnt0, before rvalid0) -> no rvalid0; all outputs 0; first contention after reset grants port 0.
- Single read: preload mem[3] = 16'h00A5; req0 = 1, we0 = 0, addr0 = 3 -> gnt0 in cycle A, mem_read = 1 / addr = 3 in A+1, rvalid0 = 1 and rdata0 = 16'h00A5 in A+2.
- Contention: req0 and req1 held high for 4 reads (addr 1, 2) -> grants alternate 0, 1, 0, 1; responses alternate with 2-cycle latency and no gaps.
- Out of range: req1 write to addr 8'd12, data 16'hBEEF -> gnt1; mem_write stays 0; rvalid1 = rerr1 = 1 two cycles later; mem[0..9] unchanged.
- Lock RMW: port 0 lock0 = 1, read addr 5 then write addr 5 = old + 1, while req1 held high -> no gnt1 until lock released; mem[5] increments exactly once.
- Lock timeout: MAX_LOCK = 8, lock1 held with continuous req1, req0 high -> gnt1 for 8 cycles, then gnt0 next cycle.
